mem_stage_sb: RTL
=================

Name: mem_stage_sb

Overview:
Parametrised successor to the memory-stage controller. Decodes pipeline loads and stores into word-aligned byte-strobed dcache requests. Stores are posted through a SB_DEPTH-entry store buffer. Loads run to completion and perform lane extraction and sign/zero extension locally. Misaligned accesses are detected and trapped. Sits between the EXE/MEM pipeline register and the single-port dcache; feeds the writeback/forward path.

Parameters:
XLEN, 32, data/address width (multiple of 8)
SB_DEPTH, 4, store buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
in_valid  in  1  pipeline op valid
in_ready  out  1  op accepted when in_valid&&in_ready
in_is_load  in  1  op is load
in_is_store  in  1  op is store
in_funct3  in  3  RV32I load/store funct3
in_addr  in  XLEN  effective address (ALU result)
in_wdata  in  XLEN  store data (rs2)
in_rd  in  5  load destination register
dc_req_valid  out  1  dcache request valid
dc_req_ready  in  1  dcache accepts request
dc_req_we  out  1  1 = write
dc_req_addr  out  XLEN  word-aligned address (addr[1:0]=0)
dc_req_wdata  out  XLEN  lane-positioned write data
dc_req_wstrb  out  XLEN/8  byte strobes
dc_resp_valid  in  1  read data valid (reads only)
dc_resp_data  in  XLEN  read word
wb_valid  out  1  load result pulse
wb_rd  out  5  load destination register
wb_data  out  XLEN  extended load data
exc_misalign  out  1  one-cycle misalignment pulse
exc_addr  out  XLEN  faulting address
sb_empty  out  1  store buffer empty (used for fence)

Behaviour:
- Reset (async): dc_req_valid=0, wb_valid=0, exc_misalign=0, exc_addr=0, wb_rd=0, wb_data=0, sb_empty=1. SB contents discarded. Load FSM -> L_IDLE. Reset mid-transaction abandons it; no resp is expected afterwards.
- in_ready is combinational: high iff FSM==L_IDLE and !(in_is_store && sb_full). A drain in the same cycle does not free a full slot.
- Ops that are neither load nor store are accepted and consumed with no action.
- Misalignment:
  - H with addr[0]!=0, or W with addr[1:0]!=0.
  - exc_misalign=1 and exc_addr=in_addr the cycle after acceptance.
  - No SB entry, no request, no wb.
- Store accept: enqueue at the tail in the same cycle.
  - Entry = {addr word, wdata<<8*addr[1:0], wstrb}.
  - wstrb: B=4'b0001<<addr[1:0], H=4'b0011<<addr[1:0], W=4'b1111.
- Drain:
  - While SB non-empty and the load FSM is not in L_REQ/L_RESP, present the head entry with we=1.
  - Dequeue on dc_req_valid&&dc_req_ready. Writes complete at handshake; there is no response.
- Request hold rule: once dc_req_valid rises, valid and all payload stay stable until dc_req_ready. dc_req_valid and payload are registered.
- Load FSM:
  - L_IDLE: on accepted aligned load, latch addr/funct3/rd.
    - Any valid SB entry with matching addr[XLEN-1:2] -> L_HAZARD.
    - Else -> L_REQ.
  - L_HAZARD: drain continues; re-check every cycle. Go to L_REQ in the cycle after no matching entry remains. No forwarding from the SB.
  - L_REQ: if a store request is pending, wait for its handshake. Then assert we=0 with the word address. Move to L_RESP on handshake.
  - L_RESP: on dc_resp_valid:
    - Shift dc_resp_data right by 8*addr[1:0].
    - LB/LH sign-extend; LBU/LHU zero-extend; LW unchanged.
    - Next cycle: wb_valid=1 for one cycle with wb_rd/wb_data; -> L_IDLE.
    - wb_valid is suppressed when rd==0.
- Load latency with no hazard, dc_req_ready=1 and 1-cycle resp: accept T, req T+1, resp T+2, wb_valid T+3.
- Pointers wrap modulo SB_DEPTH. Count range 0..SB_DEPTH. sb_empty=(count==0), registered.
- Stores accepted after a load are never issued before it. In-order program semantics are preserved because loads block the pipeline.

Decomposition:
- Package additions:
  - lstate_e {L_IDLE, L_HAZARD, L_REQ, L_RESP}.
  - sb_entry_t {word_addr, data, strb}.
  - Function for wstrb generation by funct3/offset.
  - Reuses the existing LOAD_FUN3_*/STORE_FUN3_* constants.
- Sub-module store_buffer:
  - Circular FIFO with SB_DEPTH, push/pop, full/empty.
  - Combinational match output on a word-address lookup port across all valid entries.

Test Plan:
- SB at addr 0x102, data 0x000000AB -> one write: addr 0x100, wdata 0x00AB0000, wstrb 0100; no wb.
- LB rd=5 at 0x103, resp 0x80FF_FF7F -> wb_rd=5, wb_data=0xFFFFFF80; LBU same -> 0x00000080; wb_valid at T+3.
- SW at 0x200, then LW at 0x200, dc_req_ready low 3 cycles -> load stays in L_HAZARD; store write precedes the read; read issues the cycle after dequeue.
- Four stores with SB_DEPTH=4 and dc_req_ready=0 -> in_ready low for a 5th store; raising ready drains them in order; pointers wrap; sb_empty returns to 1.
- LH at 0x301 -> exc_misalign pulse, exc_addr=0x301; no dcache request, no wb.
- Reset asserted while in L_RESP with 2 SB entries -> all outputs at reset values; a late dc_resp_valid produces no wb_valid.

Source files
------------

// File: rtl/mem_stage_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_sb_pkg
// Purpose  : Shared types, RV32I load/store funct3 encodings and helper
//            functions for the memory-stage controller with store buffer.
// Contents : lstate_e       - load FSM state encoding
//            LOAD_FUN3_*    - load funct3 encodings
//            STORE_FUN3_*   - store funct3 encodings
//            wstrb_gen()    - byte-strobe pattern for a store
//            is_misaligned()- natural-alignment check for H/W accesses
// Revision : 1.0 - initial store-buffered memory stage
// ============================================================================
package mem_stage_sb_pkg;

  localparam logic [2:0] LOAD_FUN3_LB  = 3'b000;
  localparam logic [2:0] LOAD_FUN3_LH  = 3'b001;
  localparam logic [2:0] LOAD_FUN3_LW  = 3'b010;
  localparam logic [2:0] LOAD_FUN3_LBU = 3'b100;
  localparam logic [2:0] LOAD_FUN3_LHU = 3'b101;

  localparam logic [2:0] STORE_FUN3_SB = 3'b000;
  localparam logic [2:0] STORE_FUN3_SH = 3'b001;
  localparam logic [2:0] STORE_FUN3_SW = 3'b010;

  typedef enum logic [1:0] {
    L_IDLE   = 2'd0,
    L_HAZARD = 2'd1,
    L_REQ    = 2'd2,
    L_RESP   = 2'd3
  } lstate_e;

  // Strobe pattern for a store, shifted to its byte lane. Eight bits cover
  // data widths up to 64; the caller truncates to its own strobe width.
  function automatic logic [7:0] wstrb_gen(input logic [2:0] funct3,
                                           input logic [2:0] off);
    logic [7:0] base;
    base = 8'h0F;
    case (funct3)
      STORE_FUN3_SB: base = 8'h01;
      STORE_FUN3_SH: base = 8'h03;
      default:       base = 8'h0F;
    endcase
    return base << off;
  endfunction

  // Halfword needs bit 0 clear, word needs bits [1:0] clear; bytes never trap.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] low);
    logic mis;
    mis = 1'b0;
    case (funct3[1:0])
      2'b01:   mis = low[0];
      2'b10:   mis = |low;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage : mem_stage_sb_pkg
`default_nettype wire

// File: rtl/mem_stage_sb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_sb_store_buffer
// Purpose  : Circular FIFO of posted stores with an associative word-address
//            lookup across all valid entries.
// Ports    : clk, rst_n          - clock, async active-low reset
//            push_i/push_entry_i - enqueue at tail (ignored when full)
//            pop_i               - dequeue head (ignored when empty)
//            head_o/head_next_o  - entry at head and the one behind it
//            count_o/full_o/empty_o - occupancy (empty_o registered)
//            lookup_addr_i       - word address to compare
//            match_o             - any valid entry matches
//            match_keep_o        - a match survives this cycle's pop
// Revision : 1.0 - initial store-buffered memory stage
// ============================================================================
module mem_stage_sb_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 30,
  parameter int unsigned EW    = 66,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [EW-1:0] push_entry_i,
  input  logic          pop_i,
  output logic [EW-1:0] head_o,
  output logic [EW-1:0] head_next_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  input  logic [AW-1:0] lookup_addr_i,
  output logic          match_o,
  output logic          match_keep_o
);

  logic [EW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             empty_q;
  logic             w_push;
  logic             w_pop;
  logic [DEPTH-1:0] w_hit;
  logic [DEPTH-1:0] w_hit_keep;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = empty_q;
  assign count_o = count_q;
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && (count_q != '0);

  assign head_o      = mem_q[rd_ptr_q];
  assign head_next_o = mem_q[rd_ptr_q + PW'(1)];

  always_comb begin
    count_d = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + CW'(1);
    end else if (!w_push && w_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      valid_q  <= '0;
    end else begin
      count_q <= count_d;
      empty_q <= (count_d == '0);
      // Push and pop never share an index: push needs a free slot, pop an
      // occupied one.
      if (w_push) begin
        wr_ptr_q          <= wr_ptr_q + PW'(1);
        valid_q[wr_ptr_q] <= 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q          <= rd_ptr_q + PW'(1);
        valid_q[rd_ptr_q] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  // The word address occupies the top AW bits of each entry.
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign w_hit[i]      = valid_q[i] && (mem_q[i][EW-1 -: AW] == lookup_addr_i);
    assign w_hit_keep[i] = w_hit[i] && !(w_pop && (rd_ptr_q == PW'(i)));
  end

  assign match_o      = |w_hit;
  assign match_keep_o = |w_hit_keep;

endmodule : mem_stage_sb_store_buffer
`default_nettype wire

// File: rtl/mem_stage_sb.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_sb
// Purpose  : Memory-stage controller. Turns pipeline loads/stores into
//            word-aligned, byte-strobed dcache requests. Stores are posted
//            through a store buffer; loads block until their data returns
//            and are lane-extracted and extended here. Misaligned H/W
//            accesses raise a one-cycle trap pulse.
// Ports    : clk, rst_n                        - clock, async active-low reset
//            in_*_i / in_ready_o               - EXE/MEM op handshake
//            dc_req_*_o / dc_req_ready_i       - dcache request channel
//            dc_resp_valid_i / dc_resp_data_i  - dcache read data
//            wb_valid_o / wb_rd_o / wb_data_o  - load writeback
//            exc_misalign_o / exc_addr_o       - misalignment trap
//            sb_empty_o                        - store buffer drained
// Revision : 1.0 - initial store-buffered memory stage
// ============================================================================
module mem_stage_sb
  import mem_stage_sb_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_is_load_i,
  input  logic              in_is_store_i,
  input  logic [2:0]        in_funct3_i,
  input  logic [XLEN-1:0]   in_addr_i,
  input  logic [XLEN-1:0]   in_wdata_i,
  input  logic [4:0]        in_rd_i,
  output logic              dc_req_valid_o,
  input  logic              dc_req_ready_i,
  output logic              dc_req_we_o,
  output logic [XLEN-1:0]   dc_req_addr_o,
  output logic [XLEN-1:0]   dc_req_wdata_o,
  output logic [XLEN/8-1:0] dc_req_wstrb_o,
  input  logic              dc_resp_valid_i,
  input  logic [XLEN-1:0]   dc_resp_data_i,
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              exc_misalign_o,
  output logic [XLEN-1:0]   exc_addr_o,
  output logic              sb_empty_o
);

  localparam int unsigned STRB_W = XLEN / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned WA_W   = XLEN - OFF_W;
  localparam int unsigned CW     = $clog2(SB_DEPTH) + 1;

  typedef struct packed {
    logic [WA_W-1:0]   word_addr;
    logic [XLEN-1:0]   data;
    logic [STRB_W-1:0] strb;
  } sb_entry_t;

  localparam int unsigned EW = $bits(sb_entry_t);

  // ---------------------------------------------------------------- decode
  logic [OFF_W-1:0] w_off;
  logic             w_accept;
  logic             w_misalign;
  logic             w_is_load;
  logic             w_is_store;
  logic             w_push;
  sb_entry_t        w_push_entry;

  assign w_off      = in_addr_i[OFF_W-1:0];
  assign w_accept   = in_valid_i && in_ready_o;
  assign w_misalign = (in_is_load_i || in_is_store_i) &&
                      is_misaligned(in_funct3_i, in_addr_i[1:0]);
  assign w_is_load  = in_is_load_i && !w_misalign;
  assign w_is_store = in_is_store_i && !in_is_load_i && !w_misalign;
  assign w_push     = w_accept && w_is_store;

  assign w_push_entry.word_addr = in_addr_i[XLEN-1:OFF_W];
  assign w_push_entry.data      = in_wdata_i << {w_off, 3'b000};
  assign w_push_entry.strb      = STRB_W'(wstrb_gen(in_funct3_i, 3'(w_off)));

  // ---------------------------------------------------------- state/regs
  lstate_e           state_q, state_d;
  logic [WA_W-1:0]   ld_word_q;
  logic [OFF_W-1:0]  ld_off_q;
  logic [2:0]        ld_f3_q;
  logic [4:0]        ld_rd_q;

  logic              req_valid_q, req_valid_d;
  logic              req_we_q,    req_we_d;
  logic [XLEN-1:0]   req_addr_q,  req_addr_d;
  logic [XLEN-1:0]   req_wdata_q, req_wdata_d;
  logic [STRB_W-1:0] req_strb_q,  req_strb_d;

  logic              wb_valid_q;
  logic [4:0]        wb_rd_q;
  logic [XLEN-1:0]   wb_data_q;
  logic              exc_q;
  logic [XLEN-1:0]   exc_addr_q;

  // --------------------------------------------------------- store buffer
  logic [EW-1:0]   w_head_raw;
  logic [EW-1:0]   w_head_next_raw;
  sb_entry_t       w_head;
  sb_entry_t       w_head_next;
  logic [CW-1:0]   w_sb_count;
  logic            w_sb_full;
  logic            w_sb_empty;
  logic            w_sb_match;
  logic            w_sb_match_keep;
  logic [WA_W-1:0] w_lookup;
  logic            w_store_done;

  // In L_IDLE the candidate load is still on the input bus; afterwards it is
  // the latched address. The same word is used for the read request.
  assign w_lookup     = (state_q == L_IDLE) ? in_addr_i[XLEN-1:OFF_W] : ld_word_q;
  assign w_store_done = req_valid_q && req_we_q && dc_req_ready_i;
  assign w_head       = sb_entry_t'(w_head_raw);
  assign w_head_next  = sb_entry_t'(w_head_next_raw);

  mem_stage_sb_store_buffer #(
    .DEPTH (SB_DEPTH),
    .AW    (WA_W),
    .EW    (EW)
  ) u_sb (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_i        (w_push),
    .push_entry_i  (w_push_entry),
    .pop_i         (w_store_done),
    .head_o        (w_head_raw),
    .head_next_o   (w_head_next_raw),
    .count_o       (w_sb_count),
    .full_o        (w_sb_full),
    .empty_o       (w_sb_empty),
    .lookup_addr_i (w_lookup),
    .match_o       (w_sb_match),
    .match_keep_o  (w_sb_match_keep)
  );

  // A drain freeing a slot this cycle does not admit a store into it.
  assign in_ready_o = (state_q == L_IDLE) && !(in_is_store_i && w_sb_full);

  // ------------------------------------------------------------ load FSM
  logic w_want_read;

  always_comb begin
    state_d     = state_q;
    w_want_read = 1'b0;
    unique case (state_q)
      L_IDLE: begin
        if (w_accept && w_is_load) begin
          if (w_sb_match) begin
            state_d = L_HAZARD;
          end else begin
            state_d     = L_REQ;
            w_want_read = 1'b1;
          end
        end
      end
      L_HAZARD: begin
        // match_keep ignores the entry retiring now, so the read can launch
        // on the same edge the last conflicting store leaves.
        if (!w_sb_match_keep) begin
          state_d     = L_REQ;
          w_want_read = 1'b1;
        end
      end
      L_REQ: begin
        w_want_read = !(req_valid_q && !req_we_q);
        if (req_valid_q && !req_we_q && dc_req_ready_i) begin
          state_d = L_RESP;
        end
      end
      L_RESP: begin
        if (dc_resp_valid_i) begin
          state_d = L_IDLE;
        end
      end
      default: state_d = L_IDLE;
    endcase
  end

  // ------------------------------------------------------- request register
  logic w_slot_free;
  logic w_drain_ok;

  assign w_slot_free = !req_valid_q || w_store_done;
  assign w_drain_ok  = (state_q == L_IDLE) || (state_q == L_HAZARD);

  always_comb begin
    req_valid_d = req_valid_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_strb_d  = req_strb_q;
    if (req_valid_q && dc_req_ready_i) begin
      req_valid_d = 1'b0;
    end
    if (w_want_read && w_slot_free) begin
      req_valid_d = 1'b1;
      req_we_d    = 1'b0;
      req_addr_d  = {w_lookup, {OFF_W{1'b0}}};
      req_wdata_d = '0;
      req_strb_d  = '0;
    end else if (w_drain_ok && w_slot_free) begin
      // The head stays in the buffer until its handshake, so on a retiring
      // cycle the next store to present is the one behind it.
      if (!req_valid_q && (w_sb_count != '0)) begin
        req_valid_d = 1'b1;
        req_we_d    = 1'b1;
        req_addr_d  = {w_head.word_addr, {OFF_W{1'b0}}};
        req_wdata_d = w_head.data;
        req_strb_d  = w_head.strb;
      end else if (w_store_done && (w_sb_count >= CW'(2))) begin
        req_valid_d = 1'b1;
        req_we_d    = 1'b1;
        req_addr_d  = {w_head_next.word_addr, {OFF_W{1'b0}}};
        req_wdata_d = w_head_next.data;
        req_strb_d  = w_head_next.strb;
      end
    end
  end

  // ------------------------------------------------------- load extraction
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_ext;

  assign w_shifted = dc_resp_data_i >> {ld_off_q, 3'b000};

  always_comb begin
    w_ext = w_shifted;
    case (ld_f3_q)
      LOAD_FUN3_LB:  w_ext = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
      LOAD_FUN3_LH:  w_ext = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      LOAD_FUN3_LBU: w_ext = {{(XLEN-8){1'b0}},           w_shifted[7:0]};
      LOAD_FUN3_LHU: w_ext = {{(XLEN-16){1'b0}},          w_shifted[15:0]};
      default:       w_ext = w_shifted;
    endcase
  end

  // ------------------------------------------------------------ sequential
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= L_IDLE;
      ld_word_q   <= '0;
      ld_off_q    <= '0;
      ld_f3_q     <= '0;
      ld_rd_q     <= '0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_strb_q  <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      exc_q       <= 1'b0;
      exc_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_strb_q  <= req_strb_d;

      if (state_q == L_IDLE && w_accept && w_is_load) begin
        ld_word_q <= in_addr_i[XLEN-1:OFF_W];
        ld_off_q  <= w_off;
        ld_f3_q   <= in_funct3_i;
        ld_rd_q   <= in_rd_i;
      end

      exc_q <= w_accept && w_misalign;
      if (w_accept && w_misalign) begin
        exc_addr_q <= in_addr_i;
      end

      // x0 loads still complete the bus transaction but never write back.
      wb_valid_q <= (state_q == L_RESP) && dc_resp_valid_i && (ld_rd_q != 5'd0);
      if (state_q == L_RESP && dc_resp_valid_i) begin
        wb_rd_q   <= ld_rd_q;
        wb_data_q <= w_ext;
      end
    end
  end

  assign dc_req_valid_o = req_valid_q;
  assign dc_req_we_o    = req_we_q;
  assign dc_req_addr_o  = req_addr_q;
  assign dc_req_wdata_o = req_wdata_q;
  assign dc_req_wstrb_o = req_strb_q;
  assign wb_valid_o     = wb_valid_q;
  assign wb_rd_o        = wb_rd_q;
  assign wb_data_o      = wb_data_q;
  assign exc_misalign_o = exc_q;
  assign exc_addr_o     = exc_addr_q;
  assign sb_empty_o     = w_sb_empty;

endmodule : mem_stage_sb
`default_nettype wire
